// File: rtl/wb_byte_master.sv
// wb_byte_master: byte-stream command parser driving single 32-bit Wishbone
// read/write cycles, with status/read-data bytes returned to a UART transmitter.
// Commands: 57 A3..A0 D3..D0 (write), 52 A3..A0 (read). Replies: 4B [D3..D0] / 45.
module wb_byte_master #(
    parameter int bus_timeout  = 1024,
    parameter int byte_timeout = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_SEND = 3'd4
    } state_t;

    localparam logic [7:0]  OP_WRITE  = 8'h57;
    localparam logic [7:0]  OP_READ   = 8'h52;
    localparam logic [7:0]  RSP_OK    = 8'h4B;
    localparam logic [7:0]  RSP_ERR   = 8'h45;
    // Counters start at 0 on entry, so the abort fires when they hold limit-1.
    localparam logic [31:0] BUS_LAST  = 32'(bus_timeout - 1);
    localparam logic [31:0] BYTE_LAST = 32'(byte_timeout - 1);

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [39:0] rsp_q, rsp_d;        // response bytes, sent from the top byte down
    logic [2:0]  tx_left_q, tx_left_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic [31:0] bus_cnt_q, bus_cnt_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic        tx_wr_q, tx_wr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        gap_q, gap_d;        // cycle after tx_wr, before busy is trusted

    // State and datapath registers; reset drops the bus cycle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            byte_cnt_q <= 2'd0;
            adr_q      <= 32'd0;
            wdat_q     <= 32'd0;
            rsp_q      <= 40'd0;
            tx_left_q  <= 3'd0;
            idle_cnt_q <= 32'd0;
            bus_cnt_q  <= 32'd0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'd0;
            tx_wr_q    <= 1'b0;
            tx_data_q  <= 8'd0;
            gap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            byte_cnt_q <= byte_cnt_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            rsp_q      <= rsp_d;
            tx_left_q  <= tx_left_d;
            idle_cnt_q <= idle_cnt_d;
            bus_cnt_q  <= bus_cnt_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            tx_wr_q    <= tx_wr_d;
            tx_data_q  <= tx_data_d;
            gap_q      <= gap_d;
        end
    end

    // Command parser, bus cycle control and response sequencing.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        byte_cnt_d = byte_cnt_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        rsp_d      = rsp_q;
        tx_left_d  = tx_left_q;
        idle_cnt_d = idle_cnt_q;
        bus_cnt_d  = bus_cnt_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        tx_wr_d    = 1'b0;
        tx_data_d  = tx_data_q;
        gap_d      = tx_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_avail && ((rx_data == OP_WRITE) || (rx_data == OP_READ))) begin
                    is_write_d = (rx_data == OP_WRITE);
                    byte_cnt_d = 2'd0;
                    idle_cnt_d = 32'd0;
                    state_d    = ST_ADDR;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_ADDR: begin
                if (rx_avail) begin
                    adr_d      = {adr_q[23:0], rx_data};
                    idle_cnt_d = 32'd0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (is_write_q) begin
                            state_d = ST_DATA;
                        end else begin
                            // Bus cycle starts on the edge consuming the last byte.
                            state_d   = ST_BUS;
                            cyc_d     = 1'b1;
                            we_d      = 1'b0;
                            sel_d     = 4'hF;
                            bus_cnt_d = 32'd0;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end else if (idle_cnt_q == BYTE_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
            end

            ST_DATA: begin
                if (rx_avail) begin
                    wdat_d     = {wdat_q[23:0], rx_data};
                    idle_cnt_d = 32'd0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d   = ST_BUS;
                        cyc_d     = 1'b1;
                        we_d      = 1'b1;
                        sel_d     = 4'hF;
                        bus_cnt_d = 32'd0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (idle_cnt_q == BYTE_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
            end

            ST_BUS: begin
                // Ack is checked first so it wins over err and over timeout.
                if (wb_ack_i) begin
                    if (is_write_q) begin
                        rsp_d     = {RSP_OK, 32'd0};
                        tx_left_d = 3'd1;
                    end else begin
                        rsp_d     = {RSP_OK, wb_dat_i};
                        tx_left_d = 3'd5;
                    end
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'd0;
                    state_d = ST_SEND;
                end else if (wb_err_i || (bus_cnt_q == BUS_LAST)) begin
                    rsp_d     = {RSP_ERR, 32'd0};
                    tx_left_d = 3'd1;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    sel_d     = 4'd0;
                    state_d   = ST_SEND;
                end else begin
                    bus_cnt_d = bus_cnt_q + 32'd1;
                end
            end

            ST_SEND: begin
                if (tx_left_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else if (!tx_wr_q && !gap_q && !tx_busy) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = rsp_q[39:32];
                    rsp_d     = {rsp_q[31:0], 8'h00};
                    tx_left_d = tx_left_q - 3'd1;
                    if (tx_left_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                sel_d   = 4'd0;
            end
        endcase
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = wdat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign tx_wr    = tx_wr_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master: behavioural Wishbone slave and UART
// transmitter models, hand-computed expected bytes and cycle lengths.
module tb_wb_byte_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_avail = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy = 1'b0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // slave model control: 0 ack, 1 err, 2 silent, 3 ack+err together
    int          slv_mode = 0;
    int          slv_lat = 0;
    logic [31:0] slv_rdata = 32'h0;

    // slave observations
    int          stb_cnt = 0;
    int          last_len = 0;
    int          cyc_done = 0;
    int          stab_viol = 0;
    logic [31:0] rec_adr = 32'h0;
    logic [31:0] rec_dat = 32'h0;
    logic        rec_we = 1'b0;
    logic [3:0]  rec_sel = 4'h0;

    // transmitter observations
    logic [7:0]  txq[$];
    int          tx_base = 0;
    int          tx_viol = 0;
    int          busy_cnt = 0;
    logic        prev_busy = 1'b0;
    logic        prev_tx_wr = 1'b0;
    logic        prev_cyc = 1'b0;

    wb_byte_master #(.bus_timeout(16), .byte_timeout(100)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

    always #5 clk = ~clk;

    // Wishbone slave and UART transmitter models, evaluated just after each edge.
    always @(posedge clk) begin
        #1;
        if (wb_cyc_o) begin
            stb_cnt = stb_cnt + 1;
            if (stb_cnt == 1) begin
                rec_adr = wb_adr_o;
                rec_dat = wb_dat_o;
                rec_we  = wb_we_o;
                rec_sel = wb_sel_o;
            end else if ((rec_adr !== wb_adr_o) || (rec_dat !== wb_dat_o) ||
                         (rec_we !== wb_we_o) || (rec_sel !== wb_sel_o)) begin
                stab_viol = stab_viol + 1;
            end
            if (wb_stb_o !== 1'b1) stab_viol = stab_viol + 1;
            wb_dat_i = slv_rdata;
            case (slv_mode)
                0: begin wb_ack_i = (stb_cnt == slv_lat + 1); wb_err_i = 1'b0; end
                1: begin wb_ack_i = 1'b0; wb_err_i = (stb_cnt == slv_lat + 1); end
                3: begin wb_ack_i = (stb_cnt == slv_lat + 1); wb_err_i = (stb_cnt == slv_lat + 1); end
                default: begin wb_ack_i = 1'b0; wb_err_i = 1'b0; end
            endcase
        end else begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_stb_o !== 1'b0) stab_viol = stab_viol + 1;
            if (stb_cnt > 0) begin
                last_len = stb_cnt;
                cyc_done = cyc_done + 1;
                stb_cnt  = 0;
            end
        end

        tx_busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        if (tx_wr) begin
            txq.push_back(tx_data);
            if (prev_tx_wr) tx_viol = tx_viol + 1;
            if (prev_busy) tx_viol = tx_viol + 1;
            if (prev_cyc || wb_cyc_o) tx_viol = tx_viol + 1;
            busy_cnt = 10;
        end
        prev_busy  = tx_busy;
        prev_tx_wr = tx_wr;
        prev_cyc   = wb_cyc_o;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_tx(input int i);
        if (tx_base + i < txq.size()) return {24'h0, txq[tx_base + i]};
        else return 32'hFFFF_FFFF;
    endfunction

    // called at posedge+1; returns at posedge+1 after the edge that consumed the byte
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_avail = 1'b1;
        @(posedge clk); #1;
        rx_avail = 1'b0;
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] v;
        v = {a, d};
        send_byte(8'h57);
        for (int i = 7; i >= 0; i--) send_byte(v[i*8 +: 8]);
        check_eq("cyc_rise_write", {31'd0, wb_cyc_o}, 32'd1);
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h52);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
        check_eq("cyc_rise_read", {31'd0, wb_cyc_o}, 32'd1);
    endtask

    task automatic wait_tx(input int n);
        int budget;
        budget = 3000;
        while (((txq.size() - tx_base) < n) && (budget > 0)) begin
            @(posedge clk); #1;
            budget = budget - 1;
        end
        check_eq("tx_count_bound", txq.size() - tx_base, n);
        repeat (30) @(posedge clk);
        #1;
        check_eq("tx_count_final", txq.size() - tx_base, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check_eq("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check_eq("rst_we", {31'd0, wb_we_o}, 32'd0);
        check_eq("rst_txwr", {31'd0, tx_wr}, 32'd0);
        check_eq("rst_txdata", {24'd0, tx_data}, 32'd0);
        check_eq("rst_adr", wb_adr_o, 32'd0);
        check_eq("rst_dat", wb_dat_o, 32'd0);
        check_eq("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // write, ack latency 2
        slv_mode = 0; slv_lat = 2; tx_base = txq.size(); done0 = cyc_done;
        send_write(32'h4000_0010, 32'hDEAD_BEEF);
        wait_tx(1);
        check_eq("wr_adr", rec_adr, 32'h4000_0010);
        check_eq("wr_dat", rec_dat, 32'hDEAD_BEEF);
        check_eq("wr_we", {31'd0, rec_we}, 32'd1);
        check_eq("wr_sel", {28'd0, rec_sel}, 32'hF);
        check_eq("wr_cyc_len", last_len, 32'd3);
        check_eq("wr_cycles", cyc_done - done0, 32'd1);
        check_eq("wr_rsp", get_tx(0), 32'h4B);
        check_eq("wr_sel_after", {28'd0, wb_sel_o}, 32'd0);

        // read, zero-wait ack
        slv_mode = 0; slv_lat = 0; slv_rdata = 32'h1234_5678; tx_base = txq.size();
        send_read(32'h7000_0004);
        wait_tx(5);
        check_eq("rd_adr", rec_adr, 32'h7000_0004);
        check_eq("rd_we", {31'd0, rec_we}, 32'd0);
        check_eq("rd_cyc_len", last_len, 32'd1);
        check_eq("rd_b0", get_tx(0), 32'h4B);
        check_eq("rd_b1", get_tx(1), 32'h12);
        check_eq("rd_b2", get_tx(2), 32'h34);
        check_eq("rd_b3", get_tx(3), 32'h56);
        check_eq("rd_b4", get_tx(4), 32'h78);

        // bus timeout
        slv_mode = 2; tx_base = txq.size();
        send_read(32'h0000_0008);
        wait_tx(1);
        check_eq("tmo_cyc_len", last_len, 32'd16);
        check_eq("tmo_rsp", get_tx(0), 32'h45);

        // normal command after timeout
        slv_mode = 0; slv_lat = 1; tx_base = txq.size();
        send_write(32'h2000_0000, 32'h0000_00A5);
        wait_tx(1);
        check_eq("post_tmo_rsp", get_tx(0), 32'h4B);
        check_eq("post_tmo_dat", rec_dat, 32'h0000_00A5);
        check_eq("post_tmo_len", last_len, 32'd2);

        // slave error
        slv_mode = 1; slv_lat = 1; tx_base = txq.size();
        send_write(32'h2000_0004, 32'h1111_2222);
        wait_tx(1);
        check_eq("err_rsp", get_tx(0), 32'h45);
        check_eq("err_len", last_len, 32'd2);

        // ack and err together: ack wins
        slv_mode = 3; slv_lat = 0; slv_rdata = 32'hCAFE_F00D; tx_base = txq.size();
        send_read(32'h3000_0010);
        wait_tx(5);
        check_eq("coll_b0", get_tx(0), 32'h4B);
        check_eq("coll_b4", get_tx(4), 32'h0D);

        // junk in IDLE
        tx_base = txq.size(); done0 = cyc_done;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h41);
        repeat (20) @(posedge clk);
        #1;
        check_eq("junk_cycles", cyc_done - done0, 32'd0);
        check_eq("junk_tx", txq.size() - tx_base, 32'd0);

        // gap shorter than byte timeout keeps the command
        slv_mode = 0; slv_lat = 0; tx_base = txq.size();
        send_byte(8'h57); send_byte(8'h40); send_byte(8'h00);
        repeat (50) @(posedge clk);
        #1;
        send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        check_eq("gap_cyc_rise", {31'd0, wb_cyc_o}, 32'd1);
        wait_tx(1);
        check_eq("gap_adr", rec_adr, 32'h4000_0010);
        check_eq("gap_rsp", get_tx(0), 32'h4B);

        // gap longer than byte timeout discards the partial command
        tx_base = txq.size(); done0 = cyc_done;
        send_byte(8'h57); send_byte(8'h40); send_byte(8'h00);
        repeat (110) @(posedge clk);
        #1;
        check_eq("btmo_cycles", cyc_done - done0, 32'd0);
        check_eq("btmo_tx", txq.size() - tx_base, 32'd0);
        slv_rdata = 32'hA5A5_5A5A;
        send_read(32'h1000_0000);
        wait_tx(5);
        check_eq("btmo_rd_adr", rec_adr, 32'h1000_0000);
        check_eq("btmo_rd_b0", get_tx(0), 32'h4B);
        check_eq("btmo_rd_b1", get_tx(1), 32'hA5);
        check_eq("btmo_rd_b4", get_tx(4), 32'h5A);
        check_eq("tx_protocol", tx_viol, 32'd0);
        check_eq("bus_stability", stab_viol, 32'd0);

        // reset in the middle of a bus cycle
        slv_mode = 2; tx_base = txq.size();
        send_read(32'h3000_0000);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("rstmid_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check_eq("rstmid_stb", {31'd0, wb_stb_o}, 32'd0);
        check_eq("rstmid_txwr", {31'd0, tx_wr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_eq("rstmid_no_rsp", txq.size() - tx_base, 32'd0);

        // still functional after reset
        slv_mode = 0; slv_lat = 0; slv_rdata = 32'h0BAD_F00D; tx_base = txq.size();
        send_read(32'h5000_0000);
        wait_tx(5);
        check_eq("post_rst_b0", get_tx(0), 32'h4B);
        check_eq("post_rst_b2", get_tx(2), 32'hAD);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
